// File: rtl/flush_ctrl_if.sv
// Flush controller bus: mispredict request, per-unit acks and flush/redirect outputs.
// master = ROB/pipeline side, slave = flush_ctrl side.
interface flush_ctrl_if;
    localparam int unsigned REG_W = 32;
    localparam int unsigned ACK_W = 5;

    logic               mispredict_valid;
    logic [REG_W-1:0]   mispredict_pc;
    logic [ACK_W-1:0]   ack_in;
    logic               reset_out;
    logic [REG_W-1:0]   pc_out;
    logic               redirect_valid;
    logic               busy;
    logic               timeout_err;

    modport master (
        output mispredict_valid, mispredict_pc, ack_in,
        input  reset_out, pc_out, redirect_valid, busy, timeout_err
    );

    modport slave (
        input  mispredict_valid, mispredict_pc, ack_in,
        output reset_out, pc_out, redirect_valid, busy, timeout_err
    );
endinterface

// File: rtl/flush_ctrl.sv
// Pipeline flush controller: on a committed mispredict, broadcasts a flush for
// FLUSH_MIN_CYCLES enabled cycles, waits for every unit to report cleared, then
// strobes the redirect PC to the fetcher.
// Optional macro FLUSH_TIMEOUT_EN adds an ack-wait watchdog (TIMEOUT_CYCLES)
// with a sticky timeout_err flag; without it timeout_err is tied low.
module flush_ctrl #(
    parameter int unsigned FLUSH_MIN_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES   = 64
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    flush_ctrl_if.slave   bus
);
    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACK_W = 5;

    // Parameter range guards, evaluated at elaboration.
    if (FLUSH_MIN_CYCLES < 1 || FLUSH_MIN_CYCLES > 15) begin : g_bad_flush_min
        $error("flush_ctrl: FLUSH_MIN_CYCLES out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("flush_ctrl: TIMEOUT_CYCLES out of range 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic               r_reset_out;
    logic               r_busy;
    logic               r_redirect;
    logic               w_ack_full;

    assign w_ack_full = (bus.ack_in == {ACK_W{1'b1}});

`ifdef FLUSH_TIMEOUT_EN
    localparam int unsigned WD_W = 8;

    logic [WD_W-1:0]    r_wd;
    logic [WD_W-1:0]    w_wd_nxt;
    logic               r_timeout_err;
    logic               w_timeout_err_nxt;
`endif

    // State, counters, latched PC and registered outputs; rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pc          <= '0;
            r_reset_out   <= 1'b0;
            r_busy        <= 1'b0;
            r_redirect    <= 1'b0;
`ifdef FLUSH_TIMEOUT_EN
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else if (rdy_in) begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pc          <= w_pc_nxt;
            r_reset_out   <= (w_state_nxt == S_FLUSH);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_redirect    <= (w_state_nxt == S_REDIRECT);
`ifdef FLUSH_TIMEOUT_EN
            r_wd          <= w_wd_nxt;
            r_timeout_err <= w_timeout_err_nxt;
`endif
        end
    end

    // Next-state, counter and PC-latch logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = r_pc;
`ifdef FLUSH_TIMEOUT_EN
        w_wd_nxt          = r_wd;
        w_timeout_err_nxt = r_timeout_err;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.mispredict_valid) begin
                    w_pc_nxt    = bus.mispredict_pc;
                    w_cnt_nxt   = CNT_W'(FLUSH_MIN_CYCLES - 1);
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WAIT_ACK;
`ifdef FLUSH_TIMEOUT_EN
                    w_wd_nxt    = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_WAIT_ACK: begin
                if (w_ack_full) begin
                    w_state_nxt = S_REDIRECT;
`ifdef FLUSH_TIMEOUT_EN
                    w_wd_nxt    = '0;
                end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    // Watchdog expired: give up on the missing acks and redirect anyway.
                    w_state_nxt       = S_REDIRECT;
                    w_wd_nxt          = '0;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
`endif
                end
            end
            S_REDIRECT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.reset_out      = r_reset_out;
    assign bus.pc_out         = r_pc;
    // Strobe is qualified by rdy_in so a frozen REDIRECT cycle is not consumed twice.
    assign bus.redirect_valid = r_redirect & rdy_in;
    assign bus.busy           = r_busy;
`ifdef FLUSH_TIMEOUT_EN
    assign bus.timeout_err    = r_timeout_err;
`else
    assign bus.timeout_err    = 1'b0;
`endif

endmodule

// File: doc/flush_ctrl.md
FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 Parameter FLUSH_MIN_CYCLES, default 2: cycles reset_out stays high per flush (range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 64: ack-wait watchdog limit (range 1..255), used only with FLUSH_TIMEOUT_EN.
REQ-003 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous and active-high.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 mispredict_valid  input  1  ROB commit of a mispredicted branch or jump, one-cycle pulse.
REQ-007 mispredict_pc  input  `REG_TYPE (32)  correct target PC, sampled with mispredict_valid.
REQ-008 ack_in  input  5  per-unit "cleared" level: bit0 issuer, bit1 rs_station, bit2 ls_buffer, bit3 ro_buffer, bit4 reg_file.
REQ-009 reset_out  output  1  flush request; drives the reset broadcast to all units.
REQ-010 pc_out  output  `REG_TYPE (32)  redirect PC for inst_fetcher.
REQ-011 redirect_valid  output  1  one-cycle strobe; pc_out is valid for inst_fetcher.
REQ-012 busy  output  1  high whenever state != IDLE; ROB holds commit while high.
REQ-013 timeout_err  output  1  sticky watchdog flag.

Function
REQ-014 FSM states SHALL be IDLE, FLUSH, WAIT_ACK and REDIRECT, held in registers.
REQ-015 IDLE: mispredict_valid=1 with rdy_in=1 SHALL latch mispredict_pc, load the cycle counter with FLUSH_MIN_CYCLES-1, and enter FLUSH.
REQ-016 FLUSH: reset_out=1; the counter decrements each enabled cycle; at counter 0 the FSM SHALL enter WAIT_ACK.
REQ-017 reset_out SHALL be registered, high exactly FLUSH_MIN_CYCLES enabled cycles, starting the cycle after the mispredict pulse.
REQ-018 WAIT_ACK: reset_out=0; when ack_in==5'b11111 the FSM SHALL enter REDIRECT, with no other exit except the timeout in REQ-027.
REQ-019 REDIRECT: redirect_valid=1 and pc_out=latched PC for one enabled cycle, then IDLE.
REQ-020 Latency: mispredict at edge T with acks already high -> reset_out high cycles T+1..T+FLUSH_MIN_CYCLES, redirect_valid at cycle T+FLUSH_MIN_CYCLES+2.
REQ-021 mispredict_valid outside IDLE SHALL be ignored; the latched PC is not overwritten.
REQ-022 ack_in SHALL be ignored in IDLE, FLUSH and REDIRECT; acks high during FLUSH do not shorten it.
REQ-023 rdy_in=0 SHALL hold state, counters and latched PC; redirect_valid = (state==REDIRECT) AND rdy_in; reset_out is held at its value.
REQ-024 pc_out SHALL hold the last latched PC outside REDIRECT; redirect_valid is 0 outside REDIRECT.

Reset
REQ-025 rst_in=1 at an edge, regardless of rdy_in or current state (including mid-flush), SHALL force state IDLE, reset_out=0, redirect_valid=0, busy=0, pc_out=0, all counters 0, timeout_err=0.
REQ-026 A mispredict_valid coincident with rst_in SHALL be dropped.

Configuration
REQ-027 With macro FLUSH_TIMEOUT_EN defined, a watchdog counts enabled WAIT_ACK cycles; on reaching TIMEOUT_CYCLES without full ack, the block SHALL set timeout_err (sticky until rst_in) and enter REDIRECT anyway.
REQ-028 Without FLUSH_TIMEOUT_EN, no watchdog logic is present, WAIT_ACK waits indefinitely, and timeout_err is constant 0.

Verification
REQ-029 Reset, then mispredict pc=0x0000_1000 with ack_in=5'b11111 -> reset_out high 2 cycles, redirect_valid at T+4 with pc_out=0x1000, busy low at T+5.
REQ-030 ack_in=5'b11011 until 10 cycles into WAIT_ACK, then 5'b11111 -> redirect one cycle after the full ack; reset_out low throughout the wait.
REQ-031 Second mispredict pc=0x2000 during FLUSH -> ignored; redirect shows 0x1000, exactly one redirect_valid.
REQ-032 rdy_in low for 3 cycles mid-FLUSH -> reset_out high 2 enabled cycles (5 wall cycles); no redirect_valid while rdy_in low.
REQ-033 rst_in pulse during WAIT_ACK -> next cycle IDLE, all outputs 0, no redirect issued.
REQ-034 FLUSH_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack_in held 0 -> after 8 WAIT_ACK cycles timeout_err=1 and redirect_valid pulses; timeout_err stays 1 until rst_in.
